// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-split helpers for the
// set-associative L1 instruction cache.
package icache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_BYTES = 8;
    localparam int DEF_SETS       = 16;
    localparam int DEF_WAYS       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } state_e;

    // Helpers work on a 64-bit widened address; callers cast to the field width.
    function automatic logic [63:0] getIndex(input logic [63:0] addr, input int off_w, input int idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return (addr >> off_w) & mask;
    endfunction

    function automatic logic [63:0] getTag(input logic [63:0] addr, input int off_w, input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

    function automatic logic [63:0] getOffsetWord(input logic [63:0] addr, input int off_w);
        logic [63:0] mask;
        mask = (64'd1 << (off_w - 2)) - 64'd1;
        return (addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: per-set data line, tag and valid bit, a single write port
// and an asynchronous read by index (plus a valid-only read for victim choice).
module icache_way_array #(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 25,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              srst_i,
    input  logic              flush_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  w_idx_i,
    input  logic [TAG_W-1:0]  w_tag_i,
    input  logic [LINE_W-1:0] w_data_i,
    input  logic [IDX_W-1:0]  r_idx_i,
    output logic              r_valid_o,
    output logic [TAG_W-1:0]  r_tag_o,
    output logic [LINE_W-1:0] r_data_o,
    input  logic [IDX_W-1:0]  v_idx_i,
    output logic              v_valid_o
);

    logic [LINE_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q;

    always_ff @(posedge clk) begin
        if (srst_i || flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[w_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            data_q[w_idx_i] <= w_data_i;
            tag_q[w_idx_i]  <= w_tag_i;
        end
    end

    assign r_valid_o = valid_q[r_idx_i];
    assign r_tag_o   = tag_q[r_idx_i];
    assign r_data_o  = data_q[r_idx_i];
    assign v_valid_o = valid_q[v_idx_i];

endmodule

// File: rtl/l1_icache_assoc.sv
// Set-associative L1 instruction cache with its own miss FSM, round-robin
// replacement per set and a single-cycle flush.
module l1_icache_assoc
    import icache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = DEF_WAYS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pcValid,
    input  logic [ADDR_W-1:0]       pcAddress,
    input  logic                    flush,
    output logic                    instrValid,
    output logic [31:0]             instructionCode,
    output logic                    cacheHit,
    output logic                    stall,
    output logic                    memReqValid,
    input  logic                    memReqReady,
    output logic [ADDR_W-1:0]       memReqAddr,
    input  logic                    memRespValid,
    input  logic [8*LINE_BYTES-1:0] memRespData
);

    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic [LINE_W-1:0]   line_q;
    logic                discard_q;
    logic [PTR_W-1:0]    ptr_q [SETS];

    logic [IDX_W-1:0]    pc_idx, miss_idx;
    logic [TAG_W-1:0]    pc_tag, miss_tag;
    logic [WSEL_W-1:0]   pc_word;

    logic [WAYS-1:0]     rd_valid, hit_vec, fill_valid_vec, way_we;
    logic [TAG_W-1:0]    rd_tag  [WAYS];
    logic [LINE_W-1:0]   rd_data [WAYS];
    logic [31:0]         hit_word;
    logic [PTR_W-1:0]    victim;
    logic                fill_we;

    assign pc_idx   = IDX_W'(getIndex(64'(pcAddress), OFF_W, IDX_W));
    assign pc_tag   = TAG_W'(getTag(64'(pcAddress), OFF_W, IDX_W));
    assign pc_word  = WSEL_W'(getOffsetWord(64'(pcAddress), OFF_W));
    assign miss_idx = IDX_W'(getIndex(64'(miss_addr_q), OFF_W, IDX_W));
    assign miss_tag = TAG_W'(getTag(64'(miss_addr_q), OFF_W, IDX_W));

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            icache_way_array #(
                .SETS   (SETS),
                .IDX_W  (IDX_W),
                .TAG_W  (TAG_W),
                .LINE_W (LINE_W)
            ) u_way (
                .clk       (clk),
                .srst_i    (reset),
                .flush_i   (flush),
                .we_i      (way_we[gi]),
                .w_idx_i   (miss_idx),
                .w_tag_i   (miss_tag),
                .w_data_i  (line_q),
                .r_idx_i   (pc_idx),
                .r_valid_o (rd_valid[gi]),
                .r_tag_o   (rd_tag[gi]),
                .r_data_o  (rd_data[gi]),
                .v_idx_i   (miss_idx),
                .v_valid_o (fill_valid_vec[gi])
            );
            assign hit_vec[gi] = rd_valid[gi] && (rd_tag[gi] == pc_tag);
            assign way_we[gi]  = fill_we && (victim == PTR_W'(gi));
        end
    endgenerate

    // At most one way can match, so OR-ing the masked words is a plain mux.
    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_word = hit_word | rd_data[w][{pc_word, 5'b0} +: 32];
            end
        end
    end

    always_comb begin
        logic found;
        victim = ptr_q[miss_idx];
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !fill_valid_vec[w]) begin
                victim = PTR_W'(w);
                found  = 1'b1;
            end
        end
    end

    // A flush arriving in FILL itself also suppresses the write.
    assign fill_we = (state_q == FILL) && !discard_q && !flush;

    assign cacheHit        = |hit_vec;
    assign instructionCode = hit_word;
    assign instrValid      = pcValid && cacheHit && (state_q == IDLE);
    assign stall           = (state_q != IDLE) || (pcValid && !cacheHit);
    assign memReqValid     = (state_q == REQ);
    assign memReqAddr      = miss_addr_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        case (state_q)
            IDLE: begin
                if (pcValid && !cacheHit && !flush) begin
                    state_d     = REQ;
                    miss_addr_d = {pcAddress[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end
            end
            REQ:  if (memReqReady) state_d = WAIT;
            WAIT: if (memRespValid) state_d = FILL;
            FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            discard_q   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (state_q == FILL) begin
                discard_q <= 1'b0;
            end else if (flush && (state_q != IDLE)) begin
                discard_q <= 1'b1;
            end
            if (fill_we) begin
                ptr_q[miss_idx] <= (ptr_q[miss_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[miss_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == WAIT && memRespValid) begin
            line_q <= memRespData;
        end
    end

endmodule

// File: tb/tb_l1_icache_assoc.sv
// Scoreboard bench: drivers push expected request addresses and fetched words,
// a negedge monitor pops and compares on each handshake / instrValid.
module tb_l1_icache_assoc;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcValid;
    logic [31:0] pcAddress;
    logic        flush;
    logic        instrValid;
    logic [31:0] instructionCode;
    logic        cacheHit;
    logic        stall;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memReqAddr;
    logic        memRespValid;
    logic [63:0] memRespData;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] mon_exp;

    l1_icache_assoc dut (
        .clk             (clk),
        .reset           (reset),
        .pcValid         (pcValid),
        .pcAddress       (pcAddress),
        .flush           (flush),
        .instrValid      (instrValid),
        .instructionCode (instructionCode),
        .cacheHit        (cacheHit),
        .stall           (stall),
        .memReqValid     (memReqValid),
        .memReqReady     (memReqReady),
        .memReqAddr      (memReqAddr),
        .memRespValid    (memRespValid),
        .memRespData     (memRespData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] line_of(input logic [31:0] a);
        if (a == 32'h100) return 64'h11112222_33334444;
        return {32'hD000_0000 | (a + 32'd4), 32'hD000_0000 | a};
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [63:0] l;
        l = line_of(a & ~32'h7);
        return a[2] ? l[63:32] : l[31:0];
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (memReqValid && memReqReady) begin
                $display("req  addr=%h", memReqAddr);
                if (exp_req_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_req: got %h, expected none", memReqAddr);
                end else begin
                    mon_exp = exp_req_q.pop_front();
                    chk("req_addr", 64'(memReqAddr), 64'(mon_exp));
                end
            end
            if (instrValid) begin
                $display("instr pc=%h code=%h", pcAddress, instructionCode);
                if (exp_instr_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_instr: got %h, expected none", instructionCode);
                end else begin
                    mon_exp = exp_instr_q.pop_front();
                    chk("instr_code", 64'(instructionCode), 64'(mon_exp));
                end
            end
        end
    end

    // sel 0: request handshake, sel 1: instrValid
    task automatic wait_cond(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((sel == 0 && memReqValid && memReqReady) || (sel == 1 && instrValid)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL timeout_%s: got none, expected event within 20 cycles", sel == 0 ? "req" : "instr");
        end
    endtask

    task automatic serve(input logic [63:0] line);
        bit ok;
        wait_cond(0, ok);
        if (ok) begin
            @(posedge clk); #1;
            memReqReady = 1'b0; memRespValid = 1'b1; memRespData = line;
            @(posedge clk); #1;
            memRespValid = 1'b0;
            wait_cond(1, ok);
        end
        @(posedge clk); #1;
        pcValid = 1'b0; memReqReady = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a);
        exp_req_q.push_back(a & ~32'h7);
        exp_instr_q.push_back(word_of(a));
        @(posedge clk); #1;
        pcValid = 1'b1; pcAddress = a; memReqReady = 1'b1;
        @(negedge clk);
        chk("miss_hit", 64'(cacheHit), 64'd0);
        chk("miss_stall", 64'(stall), 64'd1);
        chk("miss_code", 64'(instructionCode), 64'd0);
        serve(line_of(a & ~32'h7));
    endtask

    task automatic do_hit(input logic [31:0] a);
        exp_instr_q.push_back(word_of(a));
        @(posedge clk); #1;
        pcValid = 1'b1; pcAddress = a;
        @(negedge clk);
        chk("hit_flag", 64'(cacheHit), 64'd1);
        chk("hit_stall", 64'(stall), 64'd0);
        if (!instrValid) begin
            void'(exp_instr_q.pop_back());
            chk("hit_valid", 64'(instrValid), 64'd1);
        end
        @(posedge clk); #1;
        pcValid = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pcValid = 1'b0; pcAddress = '0; flush = 1'b0;
        memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_reqvalid", 64'(memReqValid), 64'd0);
        chk("rst_reqaddr", 64'(memReqAddr), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_instrvalid", 64'(instrValid), 64'd0);
        @(posedge clk); #1; reset = 1'b0;

        // cold miss and second word of the same line
        do_miss(32'h100);
        do_hit(32'h104);
        do_hit(32'h100);

        // replacement within set 0
        do_miss(32'h900);
        do_miss(32'h1100);
        do_hit(32'h900);
        do_hit(32'h1104);
        do_miss(32'h100);
        do_hit(32'h1100);

        // flush in IDLE, then backpressure with a wandering PC
        do_flush();
        exp_req_q.push_back(32'h100);
        exp_instr_q.push_back(32'h3333_4444);
        @(posedge clk); #1;
        pcValid = 1'b1; pcAddress = 32'h100; memReqReady = 1'b0;
        @(negedge clk);
        chk("flush_clears_hit", 64'(cacheHit), 64'd0);
        @(posedge clk); #1;
        pcAddress = 32'h904;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_reqvalid", 64'(memReqValid), 64'd1);
            chk("bp_reqaddr", 64'(memReqAddr), 64'h100);
            chk("bp_stall", 64'(stall), 64'd1);
        end
        @(posedge clk); #1;
        pcAddress = 32'h100; memReqReady = 1'b1;
        serve(line_of(32'h100));

        // flush and miss in the same IDLE cycle: no request
        @(posedge clk); #1;
        pcValid = 1'b1; pcAddress = 32'h500; flush = 1'b1; memReqReady = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; pcValid = 1'b0;
        @(negedge clk);
        chk("fm_reqvalid", 64'(memReqValid), 64'd0);
        chk("fm_stall", 64'(stall), 64'd0);
        @(posedge clk); #1; memReqReady = 1'b0;

        // flush during WAIT discards the fill
        begin
            bit ok;
            exp_req_q.push_back(32'h300);
            @(posedge clk); #1;
            pcValid = 1'b1; pcAddress = 32'h300; memReqReady = 1'b1;
            wait_cond(0, ok);
            @(posedge clk); #1;
            memReqReady = 1'b0; flush = 1'b1; pcValid = 1'b0;
            @(posedge clk); #1;
            flush = 1'b0; memRespValid = 1'b1; memRespData = line_of(32'h300);
            @(posedge clk); #1;
            memRespValid = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk("fw_stall", 64'(stall), 64'd0);
            chk("fw_reqvalid", 64'(memReqValid), 64'd0);
        end
        do_miss(32'h300);

        // reset during WAIT, late response ignored
        begin
            bit ok;
            exp_req_q.push_back(32'h400);
            @(posedge clk); #1;
            pcValid = 1'b1; pcAddress = 32'h400; memReqReady = 1'b1;
            wait_cond(0, ok);
            @(posedge clk); #1;
            memReqReady = 1'b0; reset = 1'b1; pcValid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("rw_reqvalid", 64'(memReqValid), 64'd0);
            chk("rw_stall", 64'(stall), 64'd0);
            chk("rw_reqaddr", 64'(memReqAddr), 64'd0);
            @(posedge clk); #1;
            memRespValid = 1'b1; memRespData = line_of(32'h400);
            @(posedge clk); #1;
            memRespValid = 1'b0;
            @(negedge clk);
            chk("rw_late_stall", 64'(stall), 64'd0);
            chk("rw_late_reqvalid", 64'(memReqValid), 64'd0);
        end
        do_miss(32'h400);
        do_miss(32'h300);
        do_hit(32'h404);

        repeat (2) @(posedge clk);
        chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        chk("instr_queue_empty", 64'(exp_instr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/l1_icache_assoc.md
Name: l1_icache_assoc

Overview:
- Parametrised set-associative L1 instruction cache; successor to the single-way, externally-filled instruction cache.
- Owns its miss handling: detects a miss, issues a line request to the L2/memory side over a valid/ready handshake, installs the returned line into a victim way, then resumes lookups.
- Sits between the fetch stage (PC in, instruction out, stall out) and the next memory level.
- Adds a single-cycle flush (fence.i) and round-robin replacement.

Parameters:
- ADDR_W, 32, address width.
- LINE_BYTES, 8, line size in bytes; power of two, >= 4; LINE_W = 8*LINE_BYTES.
- SETS, 16, number of sets; power of two.
- WAYS, 2, associativity; power of two, 1..8.
- Derived: OFF_W = log2(LINE_BYTES); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pcValid  in  1  fetch request valid.
- pcAddress  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- flush  in  1  invalidate all lines.
- instrValid  out  1  instructionCode is valid this cycle.
- instructionCode  out  32  fetched word.
- cacheHit  out  1  raw tag-match result for pcAddress.
- stall  out  1  cache busy with a miss; fetch must hold.
- memReqValid  out  1  line request valid.
- memReqReady  in  1  memory accepts request.
- memReqAddr  out  ADDR_W  line-aligned miss address (low OFF_W bits zero).
- memRespValid  in  1  line data valid; single beat.
- memRespData  in  LINE_W  full line; byte 0 in bits [7:0].

Behaviour:
- Address split: offset [OFF_W-1:0], index [OFF_W+IDX_W-1:OFF_W], tag [ADDR_W-1:OFF_W+IDX_W].
- Storage per set/way: data line, tag, valid bit. Per set: round-robin victim pointer of log2(WAYS) bits (0 bits when WAYS=1).
- Lookup is combinational:
  - cacheHit = OR over ways of (valid & tag match).
  - instructionCode = 32-bit word of the hit line selected by pcAddress[OFF_W-1:2].
  - When there is no hit, instructionCode is 0.
  - instrValid = pcValid & cacheHit & (state==IDLE).
- FSM states: IDLE, REQ, WAIT, FILL.
  - IDLE: pcValid & !cacheHit & !flush -> latch line address and index; go to REQ.
  - REQ: memReqValid=1; memReqAddr held stable. memReqReady=1 -> go to WAIT.
  - WAIT: memRespValid=1 -> latch memRespData; go to FILL. memRespValid is ignored in any other state.
  - FILL: write data, tag and valid into the victim way; go to IDLE.
- stall = (state != IDLE) | (state==IDLE & pcValid & !cacheHit).
- Miss penalty with an immediately-ready memory and a response one cycle after acceptance: IDLE miss -> REQ -> WAIT -> FILL -> IDLE hit, i.e. the instruction is delivered 4 cycles after the miss cycle.
- Victim selection:
  - Lowest-numbered invalid way if any exists.
  - Otherwise the way at the set's round-robin pointer.
  - The pointer increments (wrapping) on each FILL into that set. Hits do not change it.
- flush:
  - In any state, clears all valid bits on the next edge. Victim pointers are not cleared.
  - Flush in REQ: the request completes.
  - Flush in REQ, WAIT or FILL: the pending fill is marked discarded; in FILL, nothing is written; FSM returns to IDLE.
  - flush and a miss in the same IDLE cycle: flush wins; no request is issued.
- Reset:
  - Clears all valid bits, victim pointers and the discard flag; FSM goes to IDLE.
  - Reset values of outputs: memReqValid=0, memReqAddr=0, stall=0, instrValid=0.
  - Reset mid-miss abandons the miss. The memory side must be reset in the same cycle.
- A changed pcAddress during a miss has no effect: the latched miss address is used, and lookup resumes on the current PC in IDLE.
- A PC that also hits during REQ/WAIT/FILL is not served (instrValid=0).

Decomposition:
- Package icache_pkg:
  - FSM state enum.
  - Address-split helper functions: getIndex, getTag, getOffsetWord.
  - Default parameter constants.
- One natural sub-module: icache_way_array, holding data/tag/valid storage for one way. It has a write port and a combinational read by index. It is instantiated WAYS times via generate.
- FSM, victim pointers and output mux stay in the top level.

Test Plan:
- Cold miss (defaults): reset, pcValid=1, pcAddress=0x100 -> stall=1, memReqValid=1 with memReqAddr=0x100. Then ready=1 and resp 0x11112222_33334444 -> after FILL, 0x100 gives 0x33334444 and 0x104 gives 0x11112222, both with instrValid=1.
- Replacement: fill 0x100 (way0), then 0x900 (way1, same index 0), then miss 0x1100 -> way0 evicted. 0x900 still hits; 0x100 misses.
- Backpressure: memReqReady low for 5 cycles -> memReqValid=1 and memReqAddr=0x100 stable every cycle; stall=1; no state change.
- Flush in IDLE: fill 0x100, pulse flush -> next cycle 0x100 gives cacheHit=0 and a new request is issued.
- Flush during WAIT: pulse flush, then resp arrives -> FSM returns to IDLE with nothing installed; 0x100 misses again.
- Reset during WAIT: assert reset -> next cycle memReqValid=0, stall=0, all lookups miss; a late memRespValid is ignored.
